// File: rtl/wait_state_ram.sv
// Single-port memory behind a level mem_req/mem_ready handshake. Reads and writes have independent wait states.
// Define MEM_PROTECT_EN to write-protect addresses below PROT_TOP; a rejected write pulses fault.
module wait_state_ram #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_WAIT  = 0,
    parameter int WR_WAIT  = 0,
    parameter int PROT_TOP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic              mem_req,
    input  logic              we,
    output logic              mem_ready,
    output logic              busy,
    output logic              fault
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                we_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic                ready_reg;
    logic                drive_reg;
    logic                fault_reg;
    logic                do_access;
    logic                prot_hit;

    logic [DATA_W-1:0]   mem [DEPTH];

    // The access happens on the edge that leaves WAIT with the counter exhausted and the request still held.
    assign do_access = (state_reg == WAIT) && mem_req && (cnt_reg == 4'd0);

`ifdef MEM_PROTECT_EN
    assign prot_hit = we_reg && (int'(addr_reg) < PROT_TOP);
    assign fault    = fault_reg;
`else
    assign prot_hit = 1'b0;
    assign fault    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            ready_reg <= 1'b0;
            drive_reg <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    drive_reg <= 1'b0;
                    fault_reg <= 1'b0;
                    if (mem_req) begin
                        addr_reg  <= addr;
                        we_reg    <= we;
                        if (we) begin
                            wdata_reg <= data;
                        end
                        cnt_reg   <= we ? 4'(WR_WAIT) : 4'(RD_WAIT);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_req) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= DONE;
                        ready_reg <= 1'b1;
                        drive_reg <= !we_reg;
                        fault_reg <= prot_hit;
                    end
                end
                DONE: begin
                    fault_reg <= 1'b0;
                    if (!mem_req) begin
                        ready_reg <= 1'b0;
                        drive_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    drive_reg <= 1'b0;
                    fault_reg <= 1'b0;
                end
            endcase
        end
    end

    // Array and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_access && we_reg && !prot_hit) begin
            mem[addr_reg] <= wdata_reg;
        end
        if (do_access && !we_reg) begin
            rd_data_reg <= mem[addr_reg];
        end
    end

    assign mem_ready = ready_reg;
    assign busy      = (state_reg != IDLE);
    assign data      = drive_reg ? rd_data_reg : {DATA_W{1'bz}};

endmodule

// File: doc/wait_state_ram.md
Name: wait_state_ram

Overview:
- Parametrised, synthesizable single-port memory that serves the CPU's `mem_req` / `mem_ready` / `we` / bidirectional-`data` bus.
- Replaces the fixed 256x8, one-cycle, bench-only memory model.
- Adds configurable address/data width, independent programmable read and write wait states, request latching and abort handling.
- Sits between the CPU core and the system bus; one instance per memory region.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width.
- RD_WAIT, 0, extra wait cycles before read data is returned (0..15).
- WR_WAIT, 0, extra wait cycles before a write commits (0..15).
- PROT_TOP, 0, with MEM_PROTECT_EN: addresses < PROT_TOP are write-protected.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  word address from CPU.
- data  inout  DATA_W  bidirectional data bus; CPU drives on write, block drives on read.
- mem_req  in  1  request, level; held by CPU until mem_ready is seen.
- we  in  1  1 = write, 0 = read; sampled with mem_req.
- mem_ready  out  1  request complete; read data valid while high.
- busy  out  1  high in WAIT and DONE states.
- fault  out  1  one-cycle pulse on a rejected protected write; tied 0 without MEM_PROTECT_EN.

Behaviour:
- Reset (rst low, async): state=IDLE, mem_ready=0, busy=0, fault=0, data bus released (Z), wait counter=0. Array contents not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE, rising edge with mem_req=1:
  - latch addr, we, and data (if we=1);
  - load counter with RD_WAIT or WR_WAIT;
  - go to WAIT.
- WAIT, per edge:
  - mem_req=0: abort; go to IDLE, no write, no ready.
  - counter != 0: decrement.
  - counter == 0: perform the access (write commits to array, or read latches array word into output register); go to DONE with mem_ready=1 from that edge.
- Latency: mem_ready rises exactly 2+WAIT edges after the first edge sampling mem_req=1. With WAIT=0 this is 2 edges.
- DONE:
  - mem_ready held high while mem_req=1.
  - On edge with mem_req=0: mem_ready=0, go to IDLE.
  - A new request is accepted no earlier than the following edge, so there is one idle cycle between back-to-back requests.
- Data bus drive: only when state=DONE and latched we=0; otherwise Z. The block never drives while the CPU writes.
- addr, we and data changes after the request is latched are ignored until IDLE.
- Address wrap: none needed; top address 2**ADDR_W-1 is valid. Out-of-range addresses are impossible by width.
- Reset mid-WAIT or mid-DONE: access abandoned. A write not yet committed has no effect; a write committed on an earlier edge stays.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_PROTECT_EN.
- Defined: a write whose latched addr < PROT_TOP completes the normal handshake (WAIT, DONE, mem_ready), but the array is not modified and fault pulses high for one cycle on the edge entering DONE. Reads of protected addresses are normal.
- Undefined: PROT_TOP ignored, all writes commit, fault constant 0.

Test Plan:
- Reset: drive rst=0 mid-cycle with mem_req=1 -> mem_ready=0, busy=0, data=Z immediately; after release, IDLE.
- Basic, RD_WAIT=WR_WAIT=0, ADDR_W=8: write 0x5A to 0xE0 -> mem_ready 2 edges after req; read 0xE0 -> data=0x5A while mem_ready high, Z after req drops.
- Wait states, RD_WAIT=3, WR_WAIT=1: write 0xC3 to 0x10 -> ready after 3 edges; read 0x10 -> ready after 5 edges; busy high throughout; data=0xC3.
- Abort: WR_WAIT=4, write 0x77 to 0x20, drop mem_req after 2 edges -> no mem_ready; later read of 0x20 returns its prior value.
- Width/top address, ADDR_W=10, DATA_W=16: write 0xBEEF to 0x3FF, then 0x1234 to 0x000 -> reads return 0xBEEF and 0x1234; addr change during WAIT does not alter the target.
- MEM_PROTECT_EN, PROT_TOP=0x10: write 0xAA to 0x0F -> mem_ready asserts, fault pulses 1 cycle, read 0x0F unchanged; write to 0x10 -> commits, fault=0.
